fifo_status_ctrl: RTL and testbench

//  Parametrised pointer and status controller for single-clock FIFOs of depth 2**AW.

---
 rtl/fifo_status_ctrl.sv | 136 +++++++++++++
 tb/tb_fifo_status_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_status_ctrl.sv
// Pointer, occupancy and status controller for a single-clock FIFO of 2**AW entries.
// Latency: wr_en/rd_en are combinational from the requests; status is visible the cycle after the accepted operation.
// Backpressure: writes are refused while full and reads while empty; refused requests are recorded and never move the pointers.
module fifo_status_ctrl #(
    parameter int AW    = 4,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [AW:0]       af_thresh,
    input  logic [AW:0]       ae_thresh,
    input  logic              clr_err,
    output logic              wr_en,
    output logic              rd_en,
    output logic [AW-1:0]     waddr,
    output logic [AW-1:0]     raddr,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [ERR_W-1:0]  ovf_cnt,
    output logic [ERR_W-1:0]  udf_cnt,
    output logic [AW:0]       peak_count
);

    localparam int DEPTH = 1 << AW;

    // Occupancy value meaning "every entry holds data".
    localparam logic [AW:0]      FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [ERR_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [ERR_W-1:0] udf_cnt_q, udf_cnt_d;
    logic [AW:0]      peak_q, peak_d;

    logic ovf_evt;
    logic udf_evt;

    // Status decode of the registered occupancy and request qualification.
    always_comb begin
        full         = (count_q == FULL_CNT);
        empty        = (count_q == '0);
        // Threshold corner cases (0, >DEPTH, >=DEPTH) fall out of the plain compares
        // because count never exceeds DEPTH.
        almost_full  = (count_q >= af_thresh);
        almost_empty = (count_q <= ae_thresh);
        wr_en        = wr_req & ~full;
        rd_en        = rd_req & ~empty;
        ovf_evt      = wr_req & full;
        udf_evt      = rd_req & empty;
    end

    // Next-state for pointers, occupancy, sticky flags, error counters and watermark.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        peak_d    = peak_q;

        if (wr_en) wptr_d = wptr_q + (AW+1)'(1);
        if (rd_en) rptr_d = rptr_q + (AW+1)'(1);

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A new event outranks the clear so a same-cycle rejection is never lost.
        if (ovf_evt)      ovf_d = 1'b1;
        else if (clr_err) ovf_d = 1'b0;
        if (udf_evt)      udf_d = 1'b1;
        else if (clr_err) udf_d = 1'b0;

        if (clr_err)                                 ovf_cnt_d = {{(ERR_W-1){1'b0}}, ovf_evt};
        else if (ovf_evt && (ovf_cnt_q != ERR_MAX))  ovf_cnt_d = ovf_cnt_q + ERR_W'(1);
        if (clr_err)                                 udf_cnt_d = {{(ERR_W-1){1'b0}}, udf_evt};
        else if (udf_evt && (udf_cnt_q != ERR_MAX))  udf_cnt_d = udf_cnt_q + ERR_W'(1);

        // The watermark tracks the occupancy being committed this edge.
        if (clr_err)                peak_d = count_d;
        else if (count_d > peak_q)  peak_d = count_d;
    end

    // State registers; reset empties the FIFO immediately without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
            peak_q    <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
            peak_q    <= peak_d;
        end
    end

    assign waddr      = wptr_q[AW-1:0];
    assign raddr      = rptr_q[AW-1:0];
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;
    assign ovf_cnt    = ovf_cnt_q;
    assign udf_cnt    = udf_cnt_q;
    assign peak_count = peak_q;

    // Elaboration-time sanity: DEPTH must be representable in the count width.
    if (DEPTH != (1 << AW)) begin : g_bad_depth
        $error("inconsistent DEPTH");
    end

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// Bench for fifo_status_ctrl: directed scenarios followed by random traffic.
// Every cycle is compared against a reference model built from occupancy arithmetic
// and a queue of written addresses (reads must return addresses in write order).
module tb_fifo_status_ctrl;

    localparam int AW    = 4;
    localparam int ERR_W = 8;
    localparam int DEPTH = 16;
    localparam int EMAX  = 255;

    logic              clk;
    logic              rst_n;
    logic              wr_req;
    logic              rd_req;
    logic [AW:0]       af_thresh;
    logic [AW:0]       ae_thresh;
    logic              clr_err;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic [ERR_W-1:0]  ovf_cnt;
    logic [ERR_W-1:0]  udf_cnt;
    logic [AW:0]       peak_count;

    fifo_status_ctrl #(.AW(AW), .ERR_W(ERR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .clr_err      (clr_err),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .waddr        (waddr),
        .raddr        (raddr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .ovf_cnt      (ovf_cnt),
        .udf_cnt      (udf_cnt),
        .peak_count   (peak_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state.
    int n_vec;
    int n_err;
    int m_cnt;     // entries held
    int m_wr;      // total accepted writes, mod 32
    int m_rd;      // total accepted reads, mod 32
    int m_ovf;
    int m_udf;
    int m_oc;
    int m_uc;
    int m_peak;
    int addr_q[$]; // addresses of stored entries, oldest first

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wr = 0; m_rd = 0;
        m_ovf = 0; m_udf = 0; m_oc = 0; m_uc = 0; m_peak = 0;
        addr_q.delete();
    endtask

    task automatic check_all(input string w);
        int e_raddr;
        e_raddr = (addr_q.size() > 0) ? addr_q[0] : (m_rd % DEPTH);
        chk({w, ":count"},   count,        m_cnt);
        chk({w, ":full"},    full,         (m_cnt == DEPTH) ? 1 : 0);
        chk({w, ":empty"},   empty,        (m_cnt == 0) ? 1 : 0);
        chk({w, ":afull"},   almost_full,  (m_cnt >= int'(af_thresh)) ? 1 : 0);
        chk({w, ":aempty"},  almost_empty, (m_cnt <= int'(ae_thresh)) ? 1 : 0);
        chk({w, ":ovf"},     overflow,     m_ovf);
        chk({w, ":udf"},     underflow,    m_udf);
        chk({w, ":ovf_cnt"}, ovf_cnt,      m_oc);
        chk({w, ":udf_cnt"}, udf_cnt,      m_uc);
        chk({w, ":peak"},    peak_count,   m_peak);
        chk({w, ":wr_en"},   wr_en,        (wr_req && m_cnt < DEPTH) ? 1 : 0);
        chk({w, ":rd_en"},   rd_en,        (rd_req && m_cnt > 0) ? 1 : 0);
        chk({w, ":waddr"},   waddr,        m_wr % DEPTH);
        chk({w, ":raddr"},   raddr,        e_raddr);
    endtask

    task automatic model_update();
        int wacc, racc, oe, ue;
        wacc = (wr_req && m_cnt < DEPTH) ? 1 : 0;
        racc = (rd_req && m_cnt > 0) ? 1 : 0;
        oe   = (wr_req && m_cnt == DEPTH) ? 1 : 0;
        ue   = (rd_req && m_cnt == 0) ? 1 : 0;
        if (racc == 1) begin
            void'(addr_q.pop_front());
            m_rd = (m_rd + 1) % 32;
        end
        if (wacc == 1) begin
            addr_q.push_back(m_wr % DEPTH);
            m_wr = (m_wr + 1) % 32;
        end
        m_cnt = m_cnt + wacc - racc;
        if (clr_err) begin
            m_oc = oe;
            m_uc = ue;
            m_peak = m_cnt;
        end else begin
            m_oc = (m_oc + oe > EMAX) ? EMAX : m_oc + oe;
            m_uc = (m_uc + ue > EMAX) ? EMAX : m_uc + ue;
            if (m_cnt > m_peak) m_peak = m_cnt;
        end
        m_ovf = (oe == 1) ? 1 : (clr_err ? 0 : m_ovf);
        m_udf = (ue == 1) ? 1 : (clr_err ? 0 : m_udf);
    endtask

    // One cycle: drive requests, check at the falling edge, commit at the rising edge.
    task automatic step(input bit wr, input bit rd, input bit clr, input string w);
        wr_req  = wr;
        rd_req  = rd;
        clr_err = clr;
        @(negedge clk);
        check_all(w);
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0;
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to full; flag edges are covered by the per-cycle model.
        repeat (16) step(1, 0, 0, "t1_fill");
        chk("t1_count16", count, 16);
        chk("t1_full", full, 1);
        chk("t1_peak16", peak_count, 16);

        // Writes while full are refused and counted.
        repeat (3) step(1, 0, 0, "t2_ovf");
        chk("t2_ovf_cnt3", ovf_cnt, 3);
        chk("t2_ovf_set", overflow, 1);
        step(0, 0, 1, "t2_clr");
        chk("t2_ovf_clr", overflow, 0);
        chk("t2_ovf_cnt0", ovf_cnt, 0);

        // Simultaneous requests at the full and empty boundaries.
        step(1, 1, 0, "t3_full_both");
        chk("t3_count15", count, 15);
        chk("t3_ovf", overflow, 1);
        repeat (15) step(0, 1, 0, "t3_drain");
        step(1, 1, 0, "t3_empty_both");
        chk("t3_count1", count, 1);
        chk("t3_udf", underflow, 1);

        // Sustained pairs wrap both pointers; then saturate the underflow counter.
        repeat (4) step(1, 0, 0, "t4_fill");
        repeat (40) step(1, 1, 0, "t4_pairs");
        chk("t4_count5", count, 5);
        repeat (5) step(0, 1, 0, "t4_drain");
        repeat (300) step(0, 1, 0, "t4_udf");
        chk("t4_udf_sat", udf_cnt, 255);

        // Asynchronous reset mid-burst at count 9, observed before any clock edge.
        repeat (9) step(1, 0, 0, "t5_fill");
        chk("t5_count9", count, 9);
        wr_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t5_async_rst");
        chk("t5_count0", count, 0);
        chk("t5_peak0", peak_count, 0);
        #1;
        rst_n = 1'b1;
        wr_req = 1'b0;
        @(posedge clk);
        #1;

        // Clear coinciding with a refused write, then af_thresh=0 while empty.
        repeat (16) step(1, 0, 0, "t6_fill");
        step(1, 0, 1, "t6_clr_rej");
        chk("t6_ovf1", overflow, 1);
        chk("t6_ovf_cnt1", ovf_cnt, 1);
        repeat (16) step(0, 1, 0, "t6_drain");
        af_thresh = 5'd0;
        step(0, 0, 0, "t6_af0");
        chk("t6_af0_empty", almost_full, 1);

        // Random traffic with varying bias and thresholds (including out-of-range ones).
        for (int blk = 0; blk < 8; blk++) begin
            int pw;
            int pr;
            af_thresh = 5'($urandom_range(0, 17));
            ae_thresh = 5'($urandom_range(0, 17));
            pw = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int i = 0; i < 40; i++) begin
                step(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
                     ($urandom_range(0, 24) == 0), "rand");
            end
        end
        step(0, 0, 0, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
